// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg: two-entry pipeline skid register.
//
// Carries a payload across a valid/ready handshake with full throughput.
// Both handshake outputs come straight from registered state, so there is no
// combinational path from out_ready_i to in_ready_o. The main register (M)
// drives out_data_o. The skid register (S) catches the one payload accepted
// while the output is stalled.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   upstream payload valid
//   in_ready_o   block can accept a payload this cycle
//   in_data_i    upstream payload (WIDTH bits)
//   out_valid_o  downstream payload valid
//   out_ready_i  downstream accepts the payload this cycle
//   out_data_o   downstream payload (WIDTH bits)
//   flush_i      synchronous kill of all held entries
//   occupancy_o  number of held entries, 0..2
//   stall_cnt_o  cycles with out_valid_o=1 and out_ready_i=0 (stats build only)
//   drop_cnt_o   entries discarded by flush (stats build only)
//
// Build option: define PIPE_SKID_REG_STATS_EN to add the saturating
// statistics counters and their ports.
// ----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             flush_i,
`ifdef PIPE_SKID_REG_STATS_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
`endif
    output logic [1:0]       occupancy_o
);

    // The state encoding equals the number of held entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid_o = (state_q != StEmpty);
    assign in_ready_o  = (state_q != StTwo);
    assign occupancy_o = state_q;
    assign out_data_o  = main_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Flush wins. An accepted payload is dropped, and the data
            // registers keep their old contents because out_data_o is
            // don't-care while the block is empty.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_data_i;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_d  = in_data_i;
                        state_d = StTwo;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_REG_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [1:0]       drop_amt;
    logic [CNT_W:0]   drop_sum;

    // A payload that leaves in the flush cycle counts as delivered, not dropped.
    assign drop_amt = occupancy_o - {1'b0, out_fire};
    assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_amt);

    always_comb begin
        stall_d = stall_q;
        drop_d  = drop_q;
        if (out_valid_o && !out_ready_i && (stall_q != CntMax)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_i) begin
            drop_d = (drop_sum > {1'b0, CntMax}) ? CntMax : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign drop_cnt_o  = drop_q;
`else
    // Statistics disabled: no counter state and no counter ports.
`endif

endmodule
